// File: rtl/cpu_pkg.sv
// Shared types for the fetch stage: opcode width, next-PC select encoding
// and fetch FSM states.
package cpu_pkg;

  localparam int OPCODE_W = 5;

  typedef enum logic [1:0] {
    PC_BR   = 2'b00,
    PC_RIND = 2'b01,
    PC_NEXT = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    EXEC  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus: one-cycle request pulse, data returned later
// with a valid strobe.
interface instr_fetch_if #(
  parameter int ADDR_W = 16
) ();
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rddata;
  logic              mem_rdvalid;

  modport master (
    output mem_rd, mem_addr,
    input  mem_rddata, mem_rdvalid
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_rddata, mem_rdvalid
  );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch with imm8
// or imm11 offset, or register-indirect target.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       instr,
  input  logic [1:0]        pc_src,
  input  logic              ext_sel,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              pc_enable,
  output logic [ADDR_W-1:0] next_pc
);
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] imm8_ext;
  logic [ADDR_W-1:0] imm11_ext;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] br_pc;
  logic              unused_opcode_bits;

  // The low five bits are the opcode; the offsets live above them.
  assign unused_opcode_bits = ^instr[4:0];

  assign seq_pc    = pc + ADDR_W'(2);
  assign imm8_ext  = ADDR_W'($signed(instr[15:8]));
  assign imm11_ext = ADDR_W'($signed(instr[15:5]));
  assign imm_ext   = ext_sel ? imm11_ext : imm8_ext;
  assign br_pc     = seq_pc + {imm_ext[ADDR_W-2:0], 1'b0};

  always_comb begin
    next_pc = pc;
    if (pc_enable) begin
      case (pc_src)
        PC_BR:   next_pc = br_pc;
        PC_RIND: next_pc = {reg_target[ADDR_W-1:1], 1'b0};
        default: next_pc = seq_pc;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: FETCH -> WAIT -> EXEC loop holding one instruction.
// Define IFETCH_ICOUNT_EN to build the retired-instruction counter.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_if.master       mem,
  input  logic [1:0]          pc_src,
  input  logic                pc_enable,
  input  logic                ext_sel,
  input  logic [ADDR_W-1:0]   reg_target,
  input  logic                stall,
  output logic [15:0]         instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus2,
  output logic                instr_valid,
  output logic [31:0]         instr_count
);
  fetch_state_e      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic [15:0]       instr_reg;
  logic              instr_valid_reg;
  logic              retire;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next_calc (
    .pc         (pc_reg),
    .instr      (instr_reg),
    .pc_src     (pc_src),
    .ext_sel    (ext_sel),
    .reg_target (reg_target),
    .pc_enable  (pc_enable),
    .next_pc    (pc_next)
  );

  assign retire = (state_reg == EXEC) && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= FETCH;
      pc_reg          <= ADDR_W'(RESET_PC);
      instr_reg       <= 16'h0000;
      instr_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: state_reg <= WAIT;
        WAIT: begin
          // Only a response seen while waiting is ours; anything else is stale.
          if (mem.mem_rdvalid) begin
            instr_reg       <= mem.mem_rddata;
            instr_valid_reg <= 1'b1;
            state_reg       <= EXEC;
          end
        end
        EXEC: begin
          if (retire) begin
            pc_reg          <= pc_next;
            instr_valid_reg <= 1'b0;
            state_reg       <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  // Request is decoded from state so the first fetch goes out the cycle reset drops.
  assign mem.mem_rd   = (state_reg == FETCH) && !reset;
  assign mem.mem_addr = pc_reg;

  assign instr       = instr_reg;
  assign opcode      = instr_reg[OPCODE_W-1:0];
  assign pc          = pc_reg;
  assign pc_plus2    = pc_reg + ADDR_W'(2);
  assign instr_valid = instr_valid_reg;

`ifdef IFETCH_ICOUNT_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 32'd0;
    end else if (retire) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign instr_count = count_reg;
`else
  assign instr_count = 32'd0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model of fetch/wait/execute with
// randomized latency, stalls, spurious strobes and next-PC controls.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pc_src;
  logic        pc_enable;
  logic        ext_sel;
  logic [15:0] reg_target;
  logic        stall;
  logic [15:0] instr;
  logic [4:0]  opcode;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic [31:0] instr_count;

  instr_fetch_if #(.ADDR_W(16)) mem_bus ();

  instr_fetch #(.RESET_PC(16'h0000), .ADDR_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (mem_bus),
    .pc_src      (pc_src),
    .pc_enable   (pc_enable),
    .ext_sel     (ext_sel),
    .reg_target  (reg_target),
    .stall       (stall),
    .instr       (instr),
    .opcode      (opcode),
    .pc          (pc),
    .pc_plus2    (pc_plus2),
    .instr_valid (instr_valid),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_instr  = 0;

  // Model state: address of the held/next instruction, held word, retire count,
  // and what the bus/valid outputs must show in the current cycle.
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [31:0] m_count;
  logic        exp_rd;
  logic        exp_valid;
  logic        chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] cur, input logic [15:0] word,
                                             input logic [1:0] src, input logic ext,
                                             input logic [15:0] tgt, input logic en);
    int off;
    if (!en) return cur;
    case (src)
      2'b00: begin
        if (ext) off = $signed(word[15:5]);
        else     off = $signed(word[15:8]);
        return 16'(int'(cur) + 2 + off * 2);
      end
      2'b01:   return tgt & 16'hFFFE;
      default: return 16'(int'(cur) + 2);
    endcase
  endfunction

  always @(negedge clk) begin
    logic [15:0] pp2;
    if (chk_on) begin
      pp2 = m_pc + 16'd2;
      check("mem_rd", 32'(mem_bus.mem_rd), 32'(exp_rd));
      if (exp_rd) check("mem_addr", 32'(mem_bus.mem_addr), 32'(m_pc));
      check("instr_valid", 32'(instr_valid), 32'(exp_valid));
      check("instr", 32'(instr), 32'(m_instr));
      check("opcode", 32'(opcode), 32'(m_instr[4:0]));
      check("pc", 32'(pc), 32'(m_pc));
      check("pc_plus2", 32'(pc_plus2), 32'(pp2));
      check("instr_count", instr_count, m_count);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    pc_src     = 2'($urandom);
    pc_enable  = 1'($urandom);
    ext_sel    = 1'($urandom);
    reg_target = 16'($urandom);
  endtask

  // Entered during the fetch cycle; returns inside the following fetch cycle.
  task automatic do_instr(input logic [15:0] word, input int lat, input int stalls,
                          input logic [1:0] src, input logic ext, input logic [15:0] tgt,
                          input logic en, input logic inject, input logic fetch_rdv);
    logic [15:0] addr;
    addr = m_pc;
    noise();
    stall = 1'($urandom);
    mem_bus.mem_rdvalid = fetch_rdv;
    mem_bus.mem_rddata  = 16'hBEEF;
    next_cycle();
    exp_rd = 1'b0;
    exp_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      noise();
      stall = 1'($urandom);
      mem_bus.mem_rdvalid = 1'b0;
      mem_bus.mem_rddata  = 16'($urandom);
      next_cycle();
    end
    noise();
    mem_bus.mem_rdvalid = 1'b1;
    mem_bus.mem_rddata  = word;
    next_cycle();
    mem_bus.mem_rdvalid = 1'b0;
    m_instr   = word;
    exp_valid = 1'b1;
    for (int s = 0; s < stalls; s++) begin
      noise();
      stall = 1'b1;
      if (inject && s == stalls / 2) begin
        mem_bus.mem_rdvalid = 1'b1;
        mem_bus.mem_rddata  = ~word;
      end
      next_cycle();
      mem_bus.mem_rdvalid = 1'b0;
    end
    stall      = 1'b0;
    pc_src     = src;
    ext_sel    = ext;
    reg_target = tgt;
    pc_enable  = en;
    next_cycle();
    m_pc = model_next(addr, word, src, ext, tgt, en);
`ifdef IFETCH_ICOUNT_EN
    m_count = m_count + 32'd1;
`endif
    exp_rd    = 1'b1;
    exp_valid = 1'b0;
    n_instr++;
    $display("instr %0d: addr=%h word=%h lat=%0d stalls=%0d src=%b ext=%b en=%b -> next=%h",
             n_instr, addr, word, lat, stalls, src, ext, en, m_pc);
  endtask

  // Drop reset and align the model with the first (fetch) cycle after it.
  task automatic release_reset();
    reset     = 1'b0;
    m_pc      = 16'h0000;
    m_instr   = 16'h0000;
    m_count   = 32'd0;
    exp_rd    = 1'b1;
    exp_valid = 1'b0;
    chk_on    = 1'b1;
    @(negedge clk);
    check("first_fetch_rd", 32'(mem_bus.mem_rd), 32'd1);
    check("first_fetch_addr", 32'(mem_bus.mem_addr), 32'h0000);
    check("reset_instr", 32'(instr), 32'h0000);
  endtask

  task automatic pin_pc(input string name, input logic [15:0] want);
    @(negedge clk);
    check(name, 32'(mem_bus.mem_addr), 32'(want));
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    noise();
    mem_bus.mem_rdvalid = 1'b0;
    mem_bus.mem_rddata  = 16'h0000;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_mem_rd", 32'(mem_bus.mem_rd), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_count", instr_count, 32'd0);
    next_cycle();
    release_reset();

    do_instr(16'h0081, 0, 0, 2'b10, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("first_opcode", 32'(opcode), 32'h01);
    check("first_next_addr", 32'(mem_bus.mem_addr), 32'h0002);
    do_instr(16'h1234, 1, 0, 2'b01, 1'b0, 16'h0011, 1'b1, 1'b0, 1'b1);
    pin_pc("rind_0010", 16'h0010);
    do_instr(16'hFE18, 0, 0, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    pin_pc("branch_imm8_neg", 16'h000E);
    do_instr(16'h5555, 2, 1, 2'b01, 1'b0, 16'h1235, 1'b1, 1'b0, 1'b1);
    pin_pc("rind_1234", 16'h1234);
    do_instr(16'h0003, 0, 0, 2'b10, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    pin_pc("hold_refetch", 16'h1234);
    do_instr(16'h0003, 0, 0, 2'b01, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    do_instr(16'h0007, 0, 0, 2'b10, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    pin_pc("wrap_to_zero", 16'h0000);
    do_instr(16'h0040, 0, 0, 2'b00, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    pin_pc("branch_imm11", 16'h0006);
    do_instr(16'hA5C3, 0, 4, 2'b11, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    pin_pc("stall_then_src11", 16'h0008);

    // Reset while a read is outstanding; the late response must be dropped.
    mem_bus.mem_rdvalid = 1'b0;
    next_cycle();
    exp_rd = 1'b0;
    next_cycle();
    chk_on = 1'b0;
    reset  = 1'b1;
    mem_bus.mem_rdvalid = 1'b1;
    mem_bus.mem_rddata  = 16'hBEEF;
    next_cycle();
    release_reset();
    do_instr(16'h0010, 0, 0, 2'b10, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_instr(16'h0011, 1, 0, 2'b10, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_instr(16'h0012, 0, 2, 2'b10, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_instr(16'h0013, 0, 0, 2'b10, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_instr(16'h0014, 3, 0, 2'b10, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
`ifdef IFETCH_ICOUNT_EN
    check("count_after_5", instr_count, 32'd5);
`else
    check("count_disabled", instr_count, 32'd0);
`endif
    check("pc_after_5", 32'(pc), 32'h0008);

    for (int k = 0; k < 300; k++) begin
      do_instr(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               2'($urandom), 1'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the PC and memory address width.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port mem_rd, output, 1 bit: instruction read request.
REQ-006 Port mem_addr, output, ADDR_W bits: instruction read address.
REQ-007 Port mem_rddata, input, 16 bits: returned instruction word.
REQ-008 Port mem_rdvalid, input, 1 bit: mem_rddata is valid this cycle.
REQ-009 Port pc_src, input, 2 bits: next-PC select from the decoder (00 = branch, 01 = register-indirect, 10 = PC+2).
REQ-010 Port pc_enable, input, 1 bit: allow the PC to advance at retire.
REQ-011 Port ext_sel, input, 1 bit: 0 = imm8, 1 = imm11 for branch offsets.
REQ-012 Port reg_target, input, ADDR_W bits: register-indirect jump target.
REQ-013 Port stall, input, 1 bit: execute stage not finished; hold the current instruction.
REQ-014 Port instr, output, 16 bits: the held instruction register.
REQ-015 Port opcode, output, 5 bits: instr[4:0], the decoder input.
REQ-016 Port pc, output, ADDR_W bits: address of the held instruction.
REQ-017 Port pc_plus2, output, ADDR_W bits: pc+2 (writeback source for call).
REQ-018 Port instr_valid, output, 1 bit: instr/opcode are valid and in execute.
REQ-019 Port instr_count, output, 32 bits: retired-instruction counter (see Configuration).

Function
REQ-020 The FSM SHALL have states FETCH, WAIT and EXEC.
REQ-021 FETCH: mem_rd=1 and mem_addr=pc for exactly one cycle; FETCH then goes to WAIT.
REQ-022 WAIT: mem_rd=0; stay until mem_rdvalid=1, then latch mem_rddata into instr and go to EXEC.
REQ-023 mem_rdvalid outside WAIT SHALL be ignored.
REQ-024 EXEC: instr_valid=1; while stall=1, stay in EXEC with pc and instr held.
REQ-025 EXEC with stall=0 retires the instruction: update pc per REQ-026 to REQ-028, then go to FETCH.
REQ-026 At retire with pc_enable=1, next pc SHALL be:
  - pc_src 10: pc+2.
  - pc_src 00: pc+2 + (sign-extended imm << 1). imm8 = instr[15:8]; imm11 = instr[15:5].
  - pc_src 01: reg_target with bit 0 forced to 0.
  - pc_src 11: pc+2.
REQ-027 At retire with pc_enable=0, pc SHALL hold and the same address SHALL be re-fetched.
REQ-028 Address arithmetic is modulo 2^ADDR_W; wrap-around from 16'hFFFE+2 gives 16'h0000 with no flag.
REQ-029 Minimum instruction period with zero-wait memory (rdvalid the cycle after mem_rd) and no stall: 3 cycles.
REQ-030 opcode and pc_plus2 SHALL be combinational from instr and pc.

Reset
REQ-031 On reset, in any state (including WAIT with a read outstanding):
  - state becomes FETCH;
  - pc becomes RESET_PC;
  - instr becomes 16'h0000;
  - instr_valid, mem_rd and instr_count become 0.
REQ-032 The first fetch after reset SHALL be issued in the first cycle reset is low.
REQ-033 A mem_rdvalid belonging to a read issued before reset SHALL be dropped, per REQ-023.

Configuration
REQ-034 With IFETCH_ICOUNT_EN defined, instr_count SHALL increment by 1, wrapping at 2^32, on every retire (REQ-025) regardless of pc_enable.
REQ-035 Without IFETCH_ICOUNT_EN, instr_count SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-036 Package cpu_pkg SHALL hold:
  - OPCODE_W = 5;
  - the pc_src encoding enum (PC_BR, PC_RIND, PC_NEXT);
  - the fetch FSM state enum.
REQ-037 Next-PC computation SHALL be the combinational sub-module pc_next_calc (inputs pc, instr, pc_src, ext_sel, reg_target, pc_enable; output next_pc).

Verification
REQ-038 Reset, zero-wait memory returning 16'h0081 at address 0, pc_src=10, stall=0:
  - expect mem_rd at cycle 1, instr_valid at cycle 3, opcode=5'b00001;
  - the next fetch address is 16'h0002.
REQ-039 pc=16'h0010, instr=16'hFE18 (imm8=-2), pc_src=00, ext_sel=0 -> next fetch address 16'h000E.
REQ-040 pc_src=01, reg_target=16'h1235 -> fetch address 16'h1234; pc=16'hFFFE with pc_src=10 -> fetch address 16'h0000.
REQ-041 stall held 4 cycles in EXEC:
  - instr_valid=1 throughout and pc unchanged;
  - a mem_rdvalid pulse injected during the stall does not change instr.
REQ-042 Reset asserted in WAIT, then a late mem_rdvalid with 16'hBEEF -> instr stays 16'h0000 and a fresh fetch of RESET_PC is issued.
REQ-043 With IFETCH_ICOUNT_EN defined: 5 retires (one with pc_enable=0) -> instr_count=5. Without the macro -> instr_count=0.
